expr_scheduler: RTL and testbench

Shared evaluator for the three expression lanes of the calculator game. Lanes offer 12-bit expressions: operand A in [11:8], opcode in [7:4], operand B in [3:0]. A round-robin arbiter grants one lane at a time to a single ALU: add, sub and mul finish in one cycle; divide is multi-cycle restoring. Each lane's result is held in a per-lane answer register for the display/scoring logic, replacing twelve replicated operators with one datapath.

---
 rtl/expr_scheduler_if.sv | 27 ++
 rtl/expr_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_expr_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_scheduler_if.sv
// Lane-side bus of the expression scheduler: three request lanes in,
// three held answers plus pulse/error/busy status out.
interface expr_scheduler_if #(
    parameter int OPW = 4
);
    logic [2:0]         req_valid;
    logic [2:0]         req_ready;
    logic [3*OPW-1:0]   req_exp0;
    logic [3*OPW-1:0]   req_exp1;
    logic [3*OPW-1:0]   req_exp2;
    logic [OPW-1:0]     ans0;
    logic [OPW-1:0]     ans1;
    logic [OPW-1:0]     ans2;
    logic [2:0]         ans_valid;
    logic [2:0]         err;
    logic               busy;

    modport master (
        output req_valid, req_exp0, req_exp1, req_exp2,
        input  req_ready, ans0, ans1, ans2, ans_valid, err, busy
    );

    modport slave (
        input  req_valid, req_exp0, req_exp1, req_exp2,
        output req_ready, ans0, ans1, ans2, ans_valid, err, busy
    );
endinterface

// File: rtl/expr_scheduler.sv
// One shared ALU (add/sub/mul single cycle, restoring divide) time-shared
// between three expression lanes by a round-robin arbiter.
module expr_scheduler #(
    parameter int OPW = 4
) (
    input  logic            clk,
    input  logic            rst,
    expr_scheduler_if.slave bus
);
    localparam int EW = 3 * OPW;
    localparam int CW = (OPW > 2) ? $clog2(OPW) : 1;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       lane_q, lane_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [OPW-1:0]   res_q, res_d;
    logic             rerr_q, rerr_d;
    logic [OPW-1:0]   rem_q, rem_d;
    logic [OPW-1:0]   quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OPW-1:0]   ans_q [3];
    logic [OPW-1:0]   ans_d [3];
    logic [2:0]       ans_valid_q, ans_valid_d;
    logic [2:0]       err_q, err_d;

    logic [2:0]       grant;
    logic [2:0]       req_ready;
    logic [1:0]       win;
    logic [1:0]       c1, c2, c3;
    logic [EW-1:0]    win_exp;
    logic [OPW:0]     rem_sh;
    logic [OPW:0]     diff;

    function automatic logic [1:0] next_lane(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    // Search starts at the lane after the last one served.
    always_comb begin
        grant = '0;
        win   = ptr_q;
        c1    = next_lane(ptr_q);
        c2    = next_lane(c1);
        c3    = next_lane(c2);
        if (bus.req_valid[c1]) begin
            win = c1;
            grant[c1] = 1'b1;
        end else if (bus.req_valid[c2]) begin
            win = c2;
            grant[c2] = 1'b1;
        end else if (bus.req_valid[c3]) begin
            win = c3;
            grant[c3] = 1'b1;
        end
    end

    always_comb begin
        case (win)
            2'd0:    win_exp = bus.req_exp0;
            2'd1:    win_exp = bus.req_exp1;
            default: win_exp = bus.req_exp2;
        endcase
    end

    // Reset is sampled combinationally so no grant can leak out while held.
    assign req_ready = (state_q == IDLE && rst) ? grant : 3'b000;

    // One restoring step: shift in the next dividend bit, try to subtract B.
    assign rem_sh = {rem_q, quo_q[OPW-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    // NOTE: every _d gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lane_d      = lane_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        rerr_d      = rerr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        ans_d       = ans_q;
        err_d       = err_q;
        ans_valid_d = 3'b000;

        case (state_q)
            IDLE: begin
                if (req_ready != 3'b000) begin
                    if (win_exp == '0) begin
                        ptr_d = win;
                    end else begin
                        lane_d  = win;
                        a_d     = win_exp[EW-1 -: OPW];
                        op_d    = win_exp[OPW +: 4];
                        b_d     = win_exp[OPW-1:0];
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = DONE;
                rerr_d  = 1'b0;
                case (op_q)
                    OP_ADD: res_d = a_q + b_q;
                    OP_SUB: res_d = a_q - b_q;
                    OP_MUL: res_d = a_q * b_q;
                    OP_DIV: begin
                        if (b_q == '0) begin
                            res_d  = '1;
                            rerr_d = 1'b1;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_q;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
                    end
                    default: begin
                        res_d  = '0;
                        rerr_d = 1'b1;
                    end
                endcase
            end
            DIV: begin
                if (!diff[OPW]) begin
                    rem_d = diff[OPW-1:0];
                    quo_d = {quo_q[OPW-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[OPW-1:0];
                    quo_d = {quo_q[OPW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(OPW - 1)) begin
                    res_d   = quo_d;
                    rerr_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                ans_d[lane_q]       = res_q;
                err_d[lane_q]       = rerr_q;
                ans_valid_d[lane_q] = 1'b1;
                ptr_d               = lane_q;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd2;
            lane_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            rerr_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            ans_q       <= '{default: '0};
            ans_valid_q <= 3'b000;
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lane_q      <= lane_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            rerr_q      <= rerr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            ans_q       <= ans_d;
            ans_valid_q <= ans_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.ans0      = ans_q[0];
    assign bus.ans1      = ans_q[1];
    assign bus.ans2      = ans_q[2];
    assign bus.ans_valid = ans_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_expr_scheduler.sv
// Bench for expr_scheduler: transaction-level lane model checked every
// cycle, directed literal cases, then randomized lane traffic.
module tb_expr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    expr_scheduler_if #(.OPW(4)) bus ();

    expr_scheduler #(.OPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int         m_ptr;
    int         m_left;     // edges until the in-flight answer becomes visible
    int         m_lane;
    int         m_res;
    logic       m_e;
    int         m_ans [3];
    logic [2:0] m_err;
    logic [2:0] m_ansv;

    function automatic logic [11:0] lane_exp(input int i);
        if (i == 0) return bus.req_exp0;
        if (i == 1) return bus.req_exp1;
        return bus.req_exp2;
    endfunction

    function automatic int m_winner();
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr  = 2;
        m_left = 0;
        m_lane = 0;
        m_res  = 0;
        m_e    = 1'b0;
        for (int i = 0; i < 3; i++) m_ans[i] = 0;
        m_err  = 3'b000;
        m_ansv = 3'b000;
    endtask

    task automatic m_step(input int w);
        int a, op, b;
        logic [11:0] e;
        m_ansv = 3'b000;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ans[m_lane]  = m_res;
                m_err[m_lane]  = m_e;
                m_ansv[m_lane] = 1'b1;
                m_ptr          = m_lane;
            end
        end else if (w >= 0) begin
            e  = lane_exp(w);
            a  = int'(e[11:8]);
            op = int'(e[7:4]);
            b  = int'(e[3:0]);
            if (e == 12'h000) begin
                m_ptr = w;
            end else begin
                m_lane = w;
                m_e    = 1'b0;
                m_left = 2;
                case (op)
                    10: m_res = (a + b) % 16;
                    11: m_res = (a - b + 16) % 16;
                    12: m_res = (a * b) % 16;
                    13: begin
                        if (b == 0) begin
                            m_res = 15;
                            m_e   = 1'b1;
                        end else begin
                            m_res  = a / b;
                            m_left = 6;
                        end
                    end
                    default: begin
                        m_res = 0;
                        m_e   = 1'b1;
                    end
                endcase
            end
        end
    endtask

    // Single compare process: outputs are checked on every falling edge.
    initial begin
        int w;
        logic [2:0]  exp_rdy;
        logic [11:0] exp_ans;
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst) m_reset();
            w       = (rst && m_left == 0) ? m_winner() : -1;
            exp_rdy = (w >= 0) ? 3'(1 << w) : 3'b000;
            exp_ans = {4'(m_ans[2]), 4'(m_ans[1]), 4'(m_ans[0])};
            check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            check("ans_valid", 32'(bus.ans_valid), 32'(m_ansv));
            check("busy", 32'(bus.busy), 32'(m_left > 0));
            check("err", 32'(bus.err), 32'(m_err));
            check("ans", 32'({bus.ans2, bus.ans1, bus.ans0}), 32'(exp_ans));
            if (rst) m_step(w);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_exp(input int lane, input logic [11:0] e);
        case (lane)
            0:       bus.req_exp0 = e;
            1:       bus.req_exp1 = e;
            default: bus.req_exp2 = e;
        endcase
    endtask

    // Raise one lane, wait (bounded) for its grant, drop it after the transfer edge.
    task automatic send(input int lane, input logic [11:0] e, output logic [2:0] rdy);
        logic got;
        got = 1'b0;
        rdy = 3'b000;
        set_exp(lane, e);
        bus.req_valid[lane] = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready[lane]) begin
                got = 1'b1;
                rdy = bus.req_ready;
            end
        end
        check("grant_wait", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        bus.req_valid[lane] = 1'b0;
    endtask

    function automatic logic [11:0] rand_exp();
        int r;
        logic [3:0] a, b, op;
        r  = $urandom_range(0, 9);
        a  = 4'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        op = (r == 9) ? 4'($urandom) : 4'(4'hA + 4'(r % 4));
        if (r == 0) return 12'h000;
        return {a, op, b};
    endfunction

    logic [11:0] l1_exp [3] = '{12'h2B5, 12'h5C4, 12'hFAF};
    logic [3:0]  l1_ans [3] = '{4'hD, 4'h4, 4'hE};
    logic [11:0] l2_exp [4] = '{12'h9D2, 12'hFD3, 12'h7D0, 12'h3E4};
    logic [3:0]  l2_ans [4] = '{4'h4, 4'h5, 4'hF, 4'h0};
    logic        l2_err [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          l2_lat [4] = '{6, 6, 2, 2};

    initial begin
        logic [2:0] rdy;
        logic [2:0] xfer;
        bus.req_valid = 3'b000;
        bus.req_exp0  = '0;
        bus.req_exp1  = '0;
        bus.req_exp2  = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ans_valid", 32'(bus.ans_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Lane 0 add: granted immediately, answer two edges after transfer.
        send(0, 12'h3A4, rdy);
        check("t1_ready", 32'(rdy), 32'b001);
        check("t1_busy_a", 32'(bus.busy), 32'd1);
        @(posedge clk); #2;
        check("t1_busy_b", 32'(bus.busy), 32'd1);
        check("t1_no_early", 32'(bus.ans_valid), 32'd0);
        @(posedge clk); #2;
        check("t1_ans_valid", 32'(bus.ans_valid), 32'b001);
        check("t1_ans0", 32'(bus.ans0), 32'h7);
        check("t1_err0", 32'(bus.err[0]), 32'd0);
        check("t1_idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #2;
        check("t1_pulse_end", 32'(bus.ans_valid), 32'd0);

        for (int i = 0; i < 3; i++) begin
            send(1, l1_exp[i], rdy);
            repeat (2) @(posedge clk);
            #2;
            check("l1_ans_valid", 32'(bus.ans_valid), 32'b010);
            check("l1_ans1", 32'(bus.ans1), 32'(l1_ans[i]));
            check("l1_err1", 32'(bus.err[1]), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            send(2, l2_exp[i], rdy);
            repeat (l2_lat[i]) @(posedge clk);
            #2;
            check("l2_ans_valid", 32'(bus.ans_valid), 32'b100);
            check("l2_ans2", 32'(bus.ans2), 32'(l2_ans[i]));
            check("l2_err2", 32'(bus.err[2]), 32'(l2_err[i]));
        end

        // Zero expression on lane 1: accepted and discarded.
        send(1, 12'h000, rdy);
        check("zero_ready", 32'(rdy), 32'b010);
        check("zero_busy", 32'(bus.busy), 32'd0);
        check("zero_ans1", 32'(bus.ans1), 32'hE);
        @(posedge clk); #2;
        check("zero_no_valid", 32'(bus.ans_valid), 32'd0);
        set_exp(0, 12'h3A4);
        set_exp(2, 12'h7D0);
        bus.req_valid = 3'b101;
        @(negedge clk); #1;
        check("zero_next_grant", 32'(bus.req_ready), 32'b100);
        @(posedge clk); #2;
        bus.req_valid[2] = 1'b0;
        send(0, 12'h3A4, rdy);
        repeat (2) @(posedge clk);
        #2;
        check("zero_then_l0", 32'(bus.ans0), 32'h7);

        // Reset in the middle of a divide, all lanes requesting.
        send(2, 12'h9D2, rdy);
        repeat (3) @(posedge clk);
        #3;
        set_exp(0, 12'h3A4);
        set_exp(1, 12'h2B5);
        set_exp(2, 12'h9D2);
        bus.req_valid = 3'b111;
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy_mid", 32'(bus.busy), 32'd0);
        check("rst_ans", 32'({bus.ans2, bus.ans1, bus.ans0}), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        for (int g = 0; g < 6; g++) begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk); #1;
                if (bus.req_ready != 3'b000) begin
                    seen = 1'b1;
                    check("rr_order", 32'(bus.req_ready), 32'(1 << (g % 3)));
                end
            end
            check("rr_wait", 32'(seen), 32'd1);
        end
        @(posedge clk); #2;
        bus.req_valid = 3'b000;
        repeat (10) @(posedge clk);
        #2;

        // Randomized lane traffic.
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            xfer = bus.req_ready & bus.req_valid;
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (xfer[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    if (bus.req_valid[i]) set_exp(i, rand_exp());
                end else if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_exp(i, rand_exp());
                        bus.req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.req_valid = 3'b000;
        repeat (12) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
